// File: rtl/debug_pkg.sv
// Shared constants for the debug sequencer: command bytes, sizes and state encoding.
package debug_pkg;

  localparam int NB_DATA           = 32;
  localparam int NB_ADDR_REGISTERS = 5;
  localparam int N_REGISTERS       = 32;
  localparam int N_DRAIN           = 3;
  localparam int NB_BYTE           = 8;

  // The dump is the PC followed by every register.
  localparam int N_DUMP_WORDS = N_REGISTERS + 1;

  // Word index counts 0..N_DUMP_WORDS-1; drain counter holds 0..N_DRAIN.
  localparam int NB_WORD_IDX  = $clog2(N_DUMP_WORDS);
  localparam int NB_DRAIN_CNT = $clog2(N_DRAIN + 1);

  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STEP  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_SEND  = 3'd5
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Loads one word on a strobe and offers it byte by byte, MSB first, over valid/ready.
module word_serializer import debug_pkg::*; #(
  parameter int WORD_W = NB_DATA,
  parameter int BYTE_W = NB_BYTE
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
);

  localparam int N_BYTES = WORD_W / BYTE_W;
  localparam int NB_CNT  = $clog2(N_BYTES);

  logic [WORD_W-1:0] r_shift;
  logic [NB_CNT-1:0] r_cnt;
  logic              r_valid;
  logic              w_xfer;
  logic              w_last;

  assign w_xfer  = r_valid & i_ready;
  assign w_last  = (r_cnt == NB_CNT'(N_BYTES - 1));
  assign o_data  = r_shift[WORD_W-1 -: BYTE_W];
  assign o_valid = r_valid;
  assign o_done  = w_xfer & w_last;

  // Shift register advances one byte per transfer; valid drops only after the last byte moves.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift << BYTE_W;
      r_cnt   <= r_cnt + NB_CNT'(1);
      if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug sequencer: runs or steps the pipeline from UART commands, then streams a PC+register dump.
module debug_unit_ctrl import debug_pkg::*; (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NB_BYTE-1:0]           i_rx_data,
  input  logic                         i_rx_valid,
  output logic [NB_BYTE-1:0]           o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_pipe_clk_en,
  output logic                         o_debug,
  output logic [NB_ADDR_REGISTERS-1:0] o_debug_reg_addr,
  input  logic [NB_DATA-1:0]           i_debug_reg_data,
  input  logic                         i_halt,
  input  logic [NB_DATA-1:0]           i_pc,
  output logic                         o_busy
);

  localparam logic [NB_WORD_IDX-1:0] LAST_WORD = NB_WORD_IDX'(N_DUMP_WORDS - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [NB_DRAIN_CNT-1:0]      r_drain_cnt;
  logic [NB_DRAIN_CNT-1:0]      w_next_drain_cnt;
  logic [NB_WORD_IDX-1:0]       r_word_idx;
  logic [NB_WORD_IDX-1:0]       w_next_word_idx;
  logic                         r_halted;

  logic                         r_pipe_clk_en;
  logic                         r_debug;
  logic [NB_ADDR_REGISTERS-1:0] r_debug_reg_addr;
  logic                         r_busy;
  logic                         w_pipe_clk_en;
  logic                         w_debug;
  logic [NB_ADDR_REGISTERS-1:0] w_debug_reg_addr;
  logic                         w_busy;

  logic                         w_ser_load;
  logic [NB_DATA-1:0]           w_ser_word;
  logic                         w_ser_done;

  // Word 0 of the dump is the PC, later words come from the register bank read port.
  assign w_ser_load = (r_state == ST_LOAD);
  assign w_ser_word = (r_word_idx == '0) ? i_pc : i_debug_reg_data;

  word_serializer #(
    .WORD_W (NB_DATA),
    .BYTE_W (NB_BYTE)
  ) u_serializer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_ser_load),
    .i_word  (w_ser_word),
    .o_data  (o_tx_data),
    .o_valid (o_tx_valid),
    .i_ready (i_tx_ready),
    .o_done  (w_ser_done)
  );

  // State register plus drain counter, word index and sticky halted flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_word_idx  <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
      r_word_idx  <= w_next_word_idx;
      r_halted    <= r_halted | (i_halt & r_pipe_clk_en);
    end
  end

  // Next-state logic; commands are only honoured in IDLE and halt only restarts nothing once draining.
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    w_next_word_idx  = r_word_idx;
    case (r_state)
      ST_IDLE: begin
        w_next_word_idx = '0;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_RUN:  if (!r_halted) w_next_state = ST_RUN;
            CMD_STEP: w_next_state = ST_STEP;
            CMD_DUMP: w_next_state = ST_LOAD;
            default:  w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          w_next_state     = ST_DRAIN;
          w_next_drain_cnt = NB_DRAIN_CNT'(N_DRAIN);
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == NB_DRAIN_CNT'(1)) begin
          w_next_state     = ST_LOAD;
          w_next_drain_cnt = '0;
        end else begin
          w_next_drain_cnt = r_drain_cnt - NB_DRAIN_CNT'(1);
        end
      end
      ST_STEP: begin
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (w_ser_done) begin
          if (r_word_idx == LAST_WORD) begin
            w_next_state    = ST_IDLE;
            w_next_word_idx = '0;
          end else begin
            w_next_state    = ST_LOAD;
            w_next_word_idx = r_word_idx + NB_WORD_IDX'(1);
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state they describe.
  always_comb begin
    w_pipe_clk_en    = (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN) ||
                       (w_next_state == ST_STEP);
    w_debug          = (w_next_state == ST_LOAD) || (w_next_state == ST_SEND);
    w_busy           = (w_next_state != ST_IDLE);
    w_debug_reg_addr = '0;
    if (w_next_word_idx != '0) begin
      w_debug_reg_addr = NB_ADDR_REGISTERS'(w_next_word_idx - NB_WORD_IDX'(1));
    end
  end

  // Output registers; the read address is therefore stable for the whole LOAD cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pipe_clk_en    <= 1'b0;
      r_debug          <= 1'b0;
      r_debug_reg_addr <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_pipe_clk_en    <= w_pipe_clk_en;
      r_debug          <= w_debug;
      r_debug_reg_addr <= w_debug_reg_addr;
      r_busy           <= w_busy;
    end
  end

  assign o_pipe_clk_en    = r_pipe_clk_en;
  assign o_debug          = r_debug;
  assign o_debug_reg_addr = r_debug_reg_addr;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: scoreboarded dump bytes plus run/step/reset scenarios.
module tb_debug_unit_ctrl;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        pipeClkEn;
  logic        debugSel;
  logic [4:0]  dbgAddr;
  logic [31:0] regData;
  logic        halt;
  logic [31:0] pc;
  logic        busy;

  logic [31:0] regs [32];
  logic [7:0]  byteQ [$];
  logic [7:0]  rxBytes [132];
  logic [7:0]  refBytes [132];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycleCnt = 0;

  assign regData = regs[dbgAddr];

  debug_unit_ctrl dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_rx_data        (rxData),
    .i_rx_valid       (rxValid),
    .o_tx_data        (txData),
    .o_tx_valid       (txValid),
    .i_tx_ready       (txReady),
    .o_pipe_clk_en    (pipeClkEn),
    .o_debug          (debugSel),
    .o_debug_reg_addr (dbgAddr),
    .i_debug_reg_data (regData),
    .i_halt           (halt),
    .i_pc             (pc),
    .o_busy           (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to time the dump
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    rxData  = cmd;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
  endtask

  task automatic push_dump(input logic [31:0] pcVal);
    logic [31:0] w;
    for (int i = 0; i < 33; i++) begin
      w = (i == 0) ? pcVal : regs[i-1];
      for (int b = 3; b >= 0; b--) byteQ.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic drain_dump(input bit randomReady, input int nTarget,
                            output int nGot, output int endCycle);
    int          guard;
    int          enSeen;
    logic        prevStall;
    logic [7:0]  prevData;
    logic [7:0]  expByte;
    nGot = 0; guard = 0; enSeen = 0; prevStall = 1'b0; prevData = 8'h00; endCycle = 0;
    while (nGot < nTarget && guard < 3000) begin
      if (prevStall) begin
        vectors++;
        if (txValid !== 1'b1 || txData !== prevData) begin
          miscompares++;
          $display("[TB] FAIL hold_stable: valid=%b data=%02h required valid=1 data=%02h",
                   txValid, txData, prevData);
        end
      end
      if (pipeClkEn === 1'b1) enSeen++;
      txReady = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (txValid === 1'b1 && txReady) begin
        vectors++;
        if (byteQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL extra_byte: got %02h with empty scoreboard", txData);
        end else begin
          expByte = byteQ.pop_front();
          if (txData !== expByte) begin
            miscompares++;
            $display("[TB] FAIL dump_byte[%0d]: got %02h required %02h", nGot, txData, expByte);
          end
        end
        rxBytes[nGot] = txData;
        nGot++;
        if (nGot == nTarget) endCycle = cycleCnt + 1;
      end
      prevStall = (txValid === 1'b1) && !txReady;
      prevData  = txData;
      tick();
      guard++;
    end
    txReady = 1'b1;
    vectors++;
    if (nGot != nTarget) begin
      miscompares++;
      $display("[TB] FAIL dump_timeout: got %0d bytes required %0d", nGot, nTarget);
    end
    vectors++;
    if (enSeen != 0) begin
      miscompares++;
      $display("[TB] FAIL clk_en_during_dump: got %0d enabled cycles required 0", enSeen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rxData = CMD_RUN; rxValid = 1'b1;
    tick(); tick();
    vectors++;
    if ({txData, txValid, pipeClkEn, debugSel, dbgAddr, busy} !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: data=%02h valid=%b en=%b dbg=%b addr=%0d busy=%b required all 0",
               txData, txValid, pipeClkEn, debugSel, dbgAddr, busy);
    end
    reset = 1'b0; rxValid = 1'b0;
    tick(); tick();
    vectors++;
    if (pipeClkEn !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_cmd_dropped: en=%b busy=%b required 0 0", pipeClkEn, busy);
    end
  endtask

  task automatic test_ignored_input();
    send_cmd(8'h00);
    tick();
    vectors++;
    if (busy !== 1'b0 || pipeClkEn !== 1'b0 || txValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_byte: busy=%b en=%b valid=%b required 0 0 0", busy, pipeClkEn, txValid);
    end
  endtask

  task automatic test_step();
    int n, endC, loadC;
    send_cmd(CMD_STEP);
    vectors++;
    if (pipeClkEn !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_start: en=%b busy=%b required 1 1", pipeClkEn, busy);
    end
    tick();
    vectors++;
    if (pipeClkEn !== 1'b0 || debugSel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_one_cycle: en=%b dbg=%b required 0 1", pipeClkEn, debugSel);
    end
    loadC = cycleCnt;
    push_dump(pc);
    drain_dump(1'b0, 132, n, endC);
    vectors++;
    if (endC - loadC != 165) begin
      miscompares++;
      $display("[TB] FAIL dump_duration: got %0d cycles required 165", endC - loadC);
    end
    vectors++;
    if ({rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3]} !== 32'h0000_0004) begin
      miscompares++;
      $display("[TB] FAIL pc_bytes: got %02h%02h%02h%02h required 00000004",
               rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3]);
    end
    vectors++;
    if ({rxBytes[24], rxBytes[25], rxBytes[26], rxBytes[27]} !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL r5_bytes: got %02h%02h%02h%02h required DEADBEEF",
               rxBytes[24], rxBytes[25], rxBytes[26], rxBytes[27]);
    end
    vectors++;
    if (busy !== 1'b0 || txValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL step_end_idle: busy=%b valid=%b required 0 0", busy, txValid);
    end
    for (int i = 0; i < 132; i++) refBytes[i] = rxBytes[i];
  endtask

  task automatic test_backpressure();
    int n, endC, diffs;
    send_cmd(CMD_DUMP);
    vectors++;
    if (debugSel !== 1'b1 || pipeClkEn !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dump_latency: dbg=%b en=%b required 1 0", debugSel, pipeClkEn);
    end
    push_dump(pc);
    drain_dump(1'b1, 132, n, endC);
    diffs = 0;
    for (int i = 0; i < 132; i++) if (rxBytes[i] !== refBytes[i]) diffs++;
    vectors++;
    if (diffs != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_sequence: got %0d differing bytes required 0", diffs);
    end
  endtask

  task automatic test_run_to_halt();
    int en, guard, n, endC;
    send_cmd(CMD_RUN);
    en = 0; guard = 0;
    while (guard < 200) begin
      rxValid = 1'b0;
      halt    = 1'b0;
      if (pipeClkEn !== 1'b1) break;
      en++;
      if (en == 4) begin rxData = CMD_STEP; rxValid = 1'b1; end
      if (en == 10) halt = 1'b1;
      tick();
      guard++;
    end
    rxValid = 1'b0; halt = 1'b0;
    vectors++;
    if (en != 13) begin
      miscompares++;
      $display("[TB] FAIL run_enabled_cycles: got %0d required 13", en);
    end
    vectors++;
    if (debugSel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL run_load_start: dbg=%b required 1", debugSel);
    end
    push_dump(pc);
    drain_dump(1'b0, 132, n, endC);
  endtask

  task automatic test_halted_commands();
    int n, endC, en;
    send_cmd(CMD_RUN);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      if (pipeClkEn === 1'b1 || busy === 1'b1) en++;
      tick();
    end
    vectors++;
    if (en != 0) begin
      miscompares++;
      $display("[TB] FAIL run_after_halt: got %0d active cycles required 0", en);
    end
    send_cmd(CMD_STEP);
    vectors++;
    if (pipeClkEn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_after_halt: en=%b required 1", pipeClkEn);
    end
    tick();
    vectors++;
    if (pipeClkEn !== 1'b0 || debugSel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_after_halt_one: en=%b dbg=%b required 0 1", pipeClkEn, debugSel);
    end
    push_dump(pc);
    drain_dump(1'b0, 132, n, endC);
  endtask

  task automatic test_reset_mid_dump();
    int n, endC, seen;
    send_cmd(CMD_DUMP);
    push_dump(pc);
    drain_dump(1'b0, 50, n, endC);
    txReady = 1'b0;
    reset   = 1'b1;
    tick();
    vectors++;
    if (txValid !== 1'b0 || busy !== 1'b0 || debugSel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_dump: valid=%b busy=%b dbg=%b required 0 0 0", txValid, busy, debugSel);
    end
    reset = 1'b0;
    byteQ.delete();
    txReady = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (txValid === 1'b1) seen++;
      tick();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL abandoned_bytes: got %0d valid cycles required 0", seen);
    end
    pc = 32'h0000_1234;
    send_cmd(CMD_DUMP);
    push_dump(pc);
    drain_dump(1'b0, 132, n, endC);
    vectors++;
    if ({rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3]} !== 32'h0000_1234) begin
      miscompares++;
      $display("[TB] FAIL restart_pc: got %02h%02h%02h%02h required 00001234",
               rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3]);
    end
  endtask

  // Test sequence
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'hDEAD_BEEF;
    pc = 32'h0000_0004;
    halt = 1'b0;
    txReady = 1'b1;
    rxData = 8'h00;
    rxValid = 1'b0;
    reset = 1'b1;
    test_reset();
    test_ignored_input();
    test_step();
    test_backpressure();
    test_run_to_halt();
    test_halted_commands();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_unit_ctrl.md
# debug_unit_ctrl

Debug sequencer that owns the pipeline clock enable and the instruction decoder's register-bank debug read port. It takes single-byte commands from the UART receiver and runs the pipeline either continuously until halt or one cycle at a time. After each run or step it streams a state dump, the PC followed by all 32 registers, to the UART transmitter over a valid/ready handshake. It sits between the UART and the top-level pipeline and is the only driver of the pipeline's `i_clk_en`, `i_debug` and `i_debug_reg_addr`.

## Interface
- `NB_DATA`, 32, register/PC width; dump byte count per word = NB_DATA/8
- `NB_ADDR_REGISTERS`, 5, register address width
- `N_REGISTERS`, 32, registers dumped
- `N_DRAIN`, 3, extra enabled cycles after halt is seen, so EX/MA/WB retire
- `NB_BYTE`, 8, UART byte width

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_rx_data`  in  8  command byte
- `i_rx_valid`  in  1  one-cycle strobe, byte valid
- `o_tx_data`  out  8  dump byte
- `o_tx_valid`  out  1  byte offered
- `i_tx_ready`  in  1  transmitter accepts; transfer = valid & ready on an edge
- `o_pipe_clk_en`  out  1  pipeline clock enable
- `o_debug`  out  1  debug read port select
- `o_debug_reg_addr`  out  5  register index for the debug read
- `i_debug_reg_data`  in  NB_DATA  register bank read data, combinational from `o_debug_reg_addr`
- `i_halt`  in  1  decoder halt indication
- `i_pc`  in  NB_DATA  current PC
- `o_busy`  out  1  high in any state except IDLE

## Operation
- Commands, accepted only in IDLE, otherwise dropped: `'R'` (0x52) run, `'S'` (0x53) step, `'D'` (0x44) dump only. Any other byte is ignored.
- `halted` flag:
  - Set when `i_halt`=1 at an edge where `o_pipe_clk_en`=1.
  - Cleared only by reset.
  - While set, `'R'` is ignored. `'S'` and `'D'` are still accepted.
- States:
  - IDLE: waits for a command.
  - RUN: `o_pipe_clk_en`=1. On seeing halt, goes to DRAIN with counter = N_DRAIN.
  - DRAIN: `o_pipe_clk_en`=1. The counter decrements each cycle; at 1 it goes to LOAD.
  - STEP: `o_pipe_clk_en`=1 for exactly one cycle, then LOAD.
  - LOAD: latches the word for index k into a shift register.
    - k=0: `i_pc`.
    - k=1..32: `i_debug_reg_data` with `o_debug_reg_addr`=k-1.
  - SEND: offers the 4 bytes MSB first. After the 4th transfer: if k=32, go to IDLE; else k++ and go to LOAD.
- `o_debug`=1 in LOAD and SEND only. `o_pipe_clk_en` is always 0 whenever `o_debug`=1, so the debug read never competes with the pipeline's rt read.
- The dump is 33 words, 132 bytes.

## Timing
- Reset values: `o_pipe_clk_en`=0, `o_debug`=0, `o_debug_reg_addr`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_busy`=0, state IDLE, `halted`=0, k=0.
- All outputs are registered.
- Command latency:
  - `i_rx_valid` with `'R'` or `'S'` at edge E gives `o_pipe_clk_en`=1 from E+1.
  - `'D'` at edge E enters LOAD at E+1.
- Run to halt: if `i_halt` is sampled at edge H, `o_pipe_clk_en` stays high for exactly N_DRAIN more cycles, drops at H+N_DRAIN, and LOAD starts the same cycle.
- Step: exactly one cycle with `o_pipe_clk_en` high. If `i_halt` is seen at that edge, `halted` is set.
- `o_debug_reg_addr` is driven in the cycle before LOAD samples, because data is combinational and is captured at the LOAD edge.
- Handshake rules:
  - `o_tx_valid` is held high, and `o_tx_data` stable, until a transfer.
  - The next byte is presented in the cycle after a transfer.
  - `o_tx_valid` never deasserts without a transfer.
- Minimum dump time with `i_tx_ready` tied high: 5 cycles per word, 165 cycles total.
- Simultaneous events:
  - `i_rx_valid` during RUN, DRAIN, STEP, LOAD or SEND is dropped.
  - `i_halt` during DRAIN is ignored, so the counter does not restart.
- Reset mid-run or mid-dump: everything returns to reset values next cycle. The dump is abandoned with no further bytes.

## Structure
- Shared package `debug_pkg`:
  - command byte constants CMD_RUN, CMD_STEP, CMD_DUMP
  - state encoding localparams
  - N_DUMP_WORDS = N_REGISTERS+1
- Sub-module `word_serializer`: loads an NB_DATA word on a strobe, emits NB_DATA/8 bytes MSB first over valid/ready, and pulses `o_done` on the last transfer.
- The FSM, drain counter, word index and `halted` flag stay in `debug_unit_ctrl`.

## Test plan
- Reset: hold `i_reset` 2 cycles → all outputs 0, `o_busy`=0. A byte 0x52 sent during reset has no effect.
- Step: set `i_pc`=0x00000004 and reg r5=0xDEADBEEF, then send `'S'` → exactly one `o_pipe_clk_en` cycle, then 132 bytes:
  - first 4 bytes are 00 00 00 04
  - bytes 24–27 are DE AD BE EF
  - completes 165 cycles after STEP with `i_tx_ready`=1
- Run to halt: send `'R'`, raise `i_halt` at the 10th enabled cycle → `o_pipe_clk_en` high for exactly 13 cycles, then the dump starts. A later `'R'` is ignored; `'S'` still steps.
- Backpressure: toggle `i_tx_ready` pseudo-randomly during a `'D'` dump → `o_tx_data` stable while valid and not ready. The byte sequence matches the ready-always-high run and the byte count is 132.
- Ignored input: send 0x00 in IDLE and `'S'` during RUN → no state change and no extra step.
- Reset mid-dump: assert `i_reset` after byte 50 → next cycle `o_tx_valid`=0 and IDLE. A new `'D'` restarts from the PC word.
